imem_load_ctrl: RTL and testbench

- Owns the instruction memory port shared by the host instruction loader and the instruction decoder.
- Streams a program from the host into imem (LOAD phase), then issues a one-cycle decoder start, grants the decoder exclusive read access until it reports done, and signals completion.
- Sits between the host/AXI-lite front end, the imem RAM and the decoder.

---
 rtl/imem_load_ctrl.sv | 131 +++++++++++++
 tb/tb_imem_load_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction memory port owner: streams a host program into imem, then hands
// read access to the decoder for one run and reports completion.
module imem_load_ctrl #(
  parameter int IMEM_ADDR_W = 10,
  parameter int INST_W      = 32,
  parameter int CYCLE_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [IMEM_ADDR_W:0]   load_num_inst,
  input  logic                   load_abort,
  input  logic                   host_inst_v,
  input  logic [INST_W-1:0]      host_inst_data,
  output logic                   host_inst_ready,
  output logic                   load_done,
  input  logic                   run_start,
  output logic                   dec_start,
  input  logic                   dec_done,
  input  logic                   dec_read_req,
  input  logic [IMEM_ADDR_W-1:0] dec_read_addr,
  output logic                   imem_wr_en,
  output logic [IMEM_ADDR_W-1:0] imem_wr_addr,
  output logic [INST_W-1:0]      imem_wr_data,
  output logic                   imem_rd_req,
  output logic [IMEM_ADDR_W-1:0] imem_rd_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   prog_valid,
  output logic [CYCLE_CNT_W-1:0] run_cycles,
  output logic [2:0]             err,
  input  logic                   err_clr
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN_START, RUN, DONE} state_t;

  localparam logic [IMEM_ADDR_W:0]   MAX_WORDS = {1'b1, {IMEM_ADDR_W{1'b0}}};
  localparam logic [CYCLE_CNT_W-1:0] CNT_MAX   = '1;

  state_t                 state, state_nxt;
  logic [IMEM_ADDR_W-1:0] wr_ptr;
  logic [IMEM_ADDR_W:0]   remaining;
  logic                   accept;
  logic                   last_accept;
  logic                   load_ok;
  logic                   load_go;
  logic [2:0]             err_set;

  assign accept      = host_inst_v && (state == LOAD);
  assign last_accept = accept && (remaining == (IMEM_ADDR_W+1)'(1));
  assign load_ok     = (load_num_inst != '0) && (load_num_inst <= MAX_WORDS);
  assign load_go     = (state == IDLE) && load_start && load_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (load_ok) state_nxt = LOAD;
        end else if (run_start && prog_valid) begin
          state_nxt = RUN_START;
        end
      end
      LOAD:      if (load_abort || last_accept) state_nxt = IDLE;
      RUN_START: state_nxt = RUN;
      RUN:       if (dec_done) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    host_inst_ready = (state == LOAD);
    dec_start       = (state == RUN_START);
    done            = (state == DONE);
    busy            = (state != IDLE);
    imem_rd_req     = (state == RUN) && dec_read_req;
    imem_rd_addr    = (state == RUN) ? dec_read_addr : '0;
  end

  // A run request is an error whenever it cannot start a run right now.
  always_comb begin
    err_set[0] = (state == IDLE) && load_start && !load_ok;
    err_set[1] = run_start && ((state != IDLE) || load_start || !prog_valid);
    err_set[2] = dec_read_req && (state != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      load_done    <= 1'b0;
      wr_ptr       <= '0;
      remaining    <= '0;
      prog_valid   <= 1'b0;
      err          <= 3'b000;
      run_cycles   <= '0;
    end else begin
      imem_wr_en <= accept;
      load_done  <= last_accept && !load_abort;
      if (accept) begin
        imem_wr_addr <= wr_ptr;
        imem_wr_data <= host_inst_data;
        wr_ptr       <= wr_ptr + IMEM_ADDR_W'(1);
        remaining    <= remaining - (IMEM_ADDR_W+1)'(1);
      end
      if (load_go) begin
        wr_ptr     <= '0;
        remaining  <= load_num_inst;
        prog_valid <= 1'b0;
      end else if ((state == LOAD) && load_abort) begin
        prog_valid <= 1'b0;
      end else if (last_accept) begin
        prog_valid <= 1'b1;
      end
      err <= (err_clr ? 3'b000 : err) | err_set;
      if (state == RUN_START) begin
        run_cycles <= '0;
      end else if ((state == RUN) && (run_cycles != CNT_MAX)) begin
        run_cycles <= run_cycles + CYCLE_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed/randomized bench for imem_load_ctrl: expected writes, pulses and run
// counts come from the load/run rules computed with plain arithmetic.
module tb_imem_load_ctrl;

  localparam int AW      = 10;
  localparam int IW      = 32;
  localparam int CW      = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW:0]   load_num_inst = '0;
  logic          load_abort = 1'b0;
  logic          host_inst_v = 1'b0;
  logic [IW-1:0] host_inst_data = '0;
  logic          host_inst_ready;
  logic          load_done;
  logic          run_start = 1'b0;
  logic          dec_start;
  logic          dec_done = 1'b0;
  logic          dec_read_req = 1'b0;
  logic [AW-1:0] dec_read_addr = '0;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [IW-1:0] imem_wr_data;
  logic          imem_rd_req;
  logic [AW-1:0] imem_rd_addr;
  logic          busy;
  logic          done;
  logic          prog_valid;
  logic [CW-1:0] run_cycles;
  logic [2:0]    err;
  logic          err_clr = 1'b0;

  int checks = 0;
  int fails  = 0;

  imem_load_ctrl #(.IMEM_ADDR_W(AW), .INST_W(IW), .CYCLE_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_num_inst(load_num_inst), .load_abort(load_abort),
    .host_inst_v(host_inst_v), .host_inst_data(host_inst_data),
    .host_inst_ready(host_inst_ready), .load_done(load_done),
    .run_start(run_start), .dec_start(dec_start), .dec_done(dec_done),
    .dec_read_req(dec_read_req), .dec_read_addr(dec_read_addr),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .imem_rd_req(imem_rd_req), .imem_rd_addr(imem_rd_addr),
    .busy(busy), .done(done), .prog_valid(prog_valid), .run_cycles(run_cycles),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of control inputs, return just after the edge with them idle.
  task automatic applyStimulus(input logic ls, input logic rs, input logic ab,
                               input logic v, input logic [IW-1:0] d, input logic clr);
    load_start = ls; run_start = rs; load_abort = ab;
    host_inst_v = v; host_inst_data = d; err_clr = clr;
    @(posedge clk); #1;
    load_start = 1'b0; run_start = 1'b0; load_abort = 1'b0;
    host_inst_v = 1'b0; err_clr = 1'b0;
  endtask

  task automatic errClear();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("err_clear", 64'(err), 64'd0);
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({busy, done, prog_valid, load_done, dec_start, imem_wr_en,
                                     imem_rd_req, host_inst_ready, err, run_cycles}), 64'd0);
    checkOutput({tag, "_wr"}, 64'({imem_wr_addr, imem_wr_data}), 64'd0);
    checkOutput({tag, "_rd_addr"}, 64'(imem_rd_addr), 64'd0);
  endtask

  // The k-th accepted word must appear as a write to address k one cycle later.
  task automatic loadProgram(input int n, input bit gaps, input int base, input bit withRun);
    int            acc;
    logic          v;
    logic [IW-1:0] w;
    logic          last;
    load_num_inst = n[AW:0];
    applyStimulus(1'b1, withRun, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("load_busy", 64'(busy), 64'd1);
    checkOutput("load_ready", 64'(host_inst_ready), 64'd1);
    checkOutput("load_pv_cleared", 64'(prog_valid), 64'd0);
    checkOutput("load_run_err", 64'(err), withRun ? 64'd2 : 64'd0);
    acc = 0;
    while (acc < n) begin
      v    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      w    = (base >= 0) ? IW'(base + acc) : $urandom;
      last = v && (acc == n - 1);
      applyStimulus(1'b0, 1'b0, 1'b0, v, w, 1'b0);
      checkOutput("wr_en", 64'(imem_wr_en), 64'(v));
      if (v) begin
        checkOutput("wr_addr", 64'(imem_wr_addr), 64'(acc));
        checkOutput("wr_data", 64'(imem_wr_data), 64'(w));
        acc++;
      end
      checkOutput("load_done", 64'(load_done), 64'(last));
      checkOutput("prog_valid", 64'(prog_valid), 64'(last));
      checkOutput("ready_in_load", 64'(host_inst_ready), 64'(!last));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("post_load_wr_en", 64'(imem_wr_en), 64'd0);
    checkOutput("post_load_done", 64'(load_done), 64'd0);
    checkOutput("post_load_pv", 64'(prog_valid), 64'd1);
    checkOutput("post_load_busy", 64'(busy), 64'd0);
  endtask

  // Decoder finishes on the len-th cycle after dec_start; the count saturates.
  task automatic runProgram(input int len);
    logic          rd;
    logic [AW-1:0] a;
    int            expCnt;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("dec_start", 64'(dec_start), 64'd1);
    checkOutput("run_start_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("dec_start_once", 64'(dec_start), 64'd0);
    for (int k = 1; k <= len; k++) begin
      rd = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = (k == 1) ? AW'(10'h155) : AW'($urandom);
      dec_read_req = rd; dec_read_addr = a; dec_done = (k == len);
      #1;
      expCnt = (k - 1 > CNT_SAT) ? CNT_SAT : k - 1;
      checkOutput("rd_req", 64'(imem_rd_req), 64'(rd));
      checkOutput("rd_addr", 64'(imem_rd_addr), 64'(a));
      checkOutput("run_cycles_live", 64'(run_cycles), 64'(expCnt));
      checkOutput("run_done_early", 64'(done), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      dec_read_req = 1'b0; dec_done = 1'b0;
    end
    expCnt = (len > CNT_SAT) ? CNT_SAT : len;
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("done_busy", 64'(busy), 64'd1);
    checkOutput("run_cycles_final", 64'(run_cycles), 64'(expCnt));
    checkOutput("run_err", 64'(err), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("done_once", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("run_cycles_hold", 64'(run_cycles), 64'(expCnt));
    checkOutput("pv_after_run", 64'(prog_valid), 64'd1);
  endtask

  initial begin
    logic [IW-1:0] w;

    repeat (2) @(posedge clk);
    #1;
    resetChecks("reset");
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] run without program, idle read, error clear priority");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("norun_err", 64'(err), 64'd2);
    checkOutput("norun_dec_start", 64'(dec_start), 64'd0);
    checkOutput("norun_busy", 64'(busy), 64'd0);
    errClear();
    dec_read_req = 1'b1; dec_read_addr = AW'(10'h2AA);
    #1;
    checkOutput("idle_rd_req", 64'(imem_rd_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    dec_read_req = 1'b0;
    checkOutput("idle_rd_err", 64'(err), 64'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("new_err_beats_clr", 64'(err), 64'd2);
    errClear();

    $display("[TB] illegal load sizes");
    load_num_inst = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("zero_len_err", 64'(err), 64'd1);
    checkOutput("zero_len_busy", 64'(busy), 64'd0);
    errClear();
    load_num_inst = 11'd1025;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("over_len_err", 64'(err), 64'd1);
    checkOutput("over_len_ready", 64'(host_inst_ready), 64'd0);
    errClear();

    $display("[TB] back-to-back and bursty loads with runs");
    loadProgram(4, 1'b0, 'hA0, 1'b0);
    runProgram(3);
    loadProgram(3, 1'b1, -1, 1'b1);
    errClear();
    runProgram(10);

    $display("[TB] abort and run_start during load");
    load_num_inst = 11'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    w = $urandom;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, w, 1'b0);
    checkOutput("abort_wr0_addr", 64'(imem_wr_addr), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("busy_run_err", 64'(err), 64'd2);
    checkOutput("busy_run_state", 64'(host_inst_ready), 64'd1);
    errClear();
    w = $urandom;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, w, 1'b0);
    checkOutput("abort_wr_en", 64'(imem_wr_en), 64'd1);
    checkOutput("abort_wr_addr", 64'(imem_wr_addr), 64'd1);
    checkOutput("abort_wr_data", 64'(imem_wr_data), 64'(w));
    checkOutput("abort_no_done", 64'(load_done), 64'd0);
    checkOutput("abort_pv", 64'(prog_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("abort_run_err", 64'(err), 64'd2);
    checkOutput("abort_no_dec_start", 64'(dec_start), 64'd0);
    errClear();

    $display("[TB] full-depth load and random-length runs");
    loadProgram(1024, 1'b0, -1, 1'b0);
    repeat (3) runProgram($urandom_range(1, 20));
    runProgram(20);

    $display("[TB] reset during load");
    load_num_inst = 11'd5;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    #1 reset = 1'b1;
    #1 resetChecks("rst_load");
    @(negedge clk) reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("rst_load_run_err", 64'(err), 64'd2);
    errClear();
    loadProgram(5, 1'b1, -1, 1'b0);
    runProgram(6);

    $display("[TB] reset during run");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("mid_run_cycles", 64'(run_cycles), 64'd2);
    #1 reset = 1'b1;
    #1 resetChecks("rst_run");
    @(negedge clk) reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(2, 1'b0, -1, 1'b0);
    runProgram(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
